// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: multicycle signed 32-bit multiply / divide unit for the execute stage.
// One carry-lookahead adder is time-shared across all states: Booth radix-2
// multiplication (32 iterations) and restoring division with sign fix-up on entry and exit.
//
// Ports:
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   ctrl_MULT      1-cycle start pulse, multiply (wins when both pulses are high)
//   ctrl_DIV       1-cycle start pulse, divide
//   data_operandA  multiplicand / dividend, sampled on the start edge
//   data_operandB  multiplier / divisor, sampled on the start edge
//   data_result    product low word / quotient, held until the next completion
//   data_exception product overflow, divide-by-zero, or 0x80000000 / -1
//   data_resultRDY 1-cycle result-valid strobe
//   busy           high while an operation is in flight
//
// cla32 is the shared 32-bit carry-lookahead adder. It uses 4-bit lookahead groups
// chained group to group. ovf is the signed overflow of S = A + B + Cin.

module cla32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        ovf
);
  logic [31:0] p_s;
  logic [31:0] g_s;
  logic [32:0] c_s;

  // bit propagate / generate terms
  always_comb begin
    p_s = A ^ B;
    g_s = A & B;
  end

  // group lookahead carries, evaluated group by group in a single block
  always_comb begin
    c_s = 33'd0;
    c_s[0] = Cin;
    for (int k = 0; k < 8; k++) begin
      c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & c_s[4*k]);
      c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
      c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
      c_s[4*k+4] = g_s[4*k+3] | (p_s[4*k+3] & g_s[4*k+2])
                 | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
    end
  end

  // sum and signed overflow
  always_comb begin
    S   = p_s ^ c_s[31:0];
    ovf = c_s[31] ^ c_s[32];
  end
endmodule

module multdiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    MUL         = 3'd1,
    DIV_NEG_IN  = 3'd2,
    DIV         = 3'd3,
    DIV_NEG_OUT = 3'd4,
    DONE        = 3'd5
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] acc_r;      // Booth high word, or division remainder
  logic [WIDTH-1:0] q_r;        // Booth multiplier / low word, or quotient
  logic             q1_r;       // Booth q_{-1}
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic             dbz_r;      // divide-by-zero seen; completes on the next edge
  logic [WIDTH-1:0] result_r;
  logic             exc_r;
  logic             rdy_r;
  logic             busy_r;

  logic [WIDTH-1:0] add_a_s;
  logic [WIDTH-1:0] add_b_s;
  logic             add_cin_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;
  logic             c32_s;
  logic [WIDTH-1:0] rsh_s;
  logic [WIDTH-1:0] acc_shift_s;
  logic [WIDTH-1:0] q_shift_s;
  logic [WIDTH-1:0] q_fix_s;

  cla32 u_cla (
    .A   (add_a_s),
    .B   (add_b_s),
    .Cin (add_cin_s),
    .S   (sum_s),
    .ovf (ovf_s)
  );

  // adder operand / carry-in selection by state
  always_comb begin
    add_a_s   = {WIDTH{1'b0}};
    add_b_s   = {WIDTH{1'b0}};
    add_cin_s = 1'b0;
    case (state_r)
      MUL: begin
        add_a_s = acc_r;
        case ({q_r[0], q1_r})
          2'b01: begin
            add_b_s   = opa_r;
            add_cin_s = 1'b0;
          end
          2'b10: begin
            add_b_s   = ~opa_r;
            add_cin_s = 1'b1;
          end
          default: begin
            add_b_s   = {WIDTH{1'b0}};
            add_cin_s = 1'b0;
          end
        endcase
      end
      DIV_NEG_IN: begin
        add_a_s   = ~opa_r;
        add_cin_s = 1'b1;
      end
      DIV: begin
        add_a_s = rsh_s;
        // a negative divisor is already minus its magnitude, so add it directly
        if (opb_r[WIDTH-1]) begin
          add_b_s   = opb_r;
          add_cin_s = 1'b0;
        end else begin
          add_b_s   = ~opb_r;
          add_cin_s = 1'b1;
        end
      end
      DIV_NEG_OUT: begin
        add_a_s   = ~q_r;
        add_cin_s = 1'b1;
      end
      default: begin
        add_a_s   = {WIDTH{1'b0}};
        add_b_s   = {WIDTH{1'b0}};
        add_cin_s = 1'b0;
      end
    endcase
  end

  // derived datapath terms: carry-out, shifted values, final quotient sign fix
  always_comb begin
    c32_s = (add_a_s[WIDTH-1] & add_b_s[WIDTH-1])
          | ((add_a_s[WIDTH-1] ^ add_b_s[WIDTH-1]) & ~sum_s[WIDTH-1]);
    rsh_s = {acc_r[WIDTH-2:0], q_r[WIDTH-1]};
    // S31^ovf is the true sign of the 33-bit acc+-M, correct even for M = 0x80000000
    acc_shift_s = {sum_s[WIDTH-1] ^ ovf_s, sum_s[WIDTH-1:1]};
    q_shift_s   = {sum_s[0], q_r[WIDTH-1:1]};
    if (opa_r[WIDTH-1] ^ opb_r[WIDTH-1]) begin
      q_fix_s = sum_s;
    end else begin
      q_fix_s = q_r;
    end
  end

  // control FSM, working registers and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      q_r      <= {WIDTH{1'b0}};
      q1_r     <= 1'b0;
      opa_r    <= {WIDTH{1'b0}};
      opb_r    <= {WIDTH{1'b0}};
      dbz_r    <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      exc_r    <= 1'b0;
      rdy_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      rdy_r <= 1'b0;
      dbz_r <= 1'b0;
      if (ctrl_MULT || ctrl_DIV) begin
        // a start in any state abandons whatever was in flight
        opa_r <= data_operandA;
        opb_r <= data_operandB;
        cnt_r <= {CNT_W{1'b0}};
        acc_r <= {WIDTH{1'b0}};
        q1_r  <= 1'b0;
        q_r   <= data_operandB;
        if (ctrl_MULT) begin
          state_r <= MUL;
          busy_r  <= 1'b1;
        end else if (data_operandB == {WIDTH{1'b0}}) begin
          // divide-by-zero never looks busy; it completes on the next edge
          state_r <= IDLE;
          dbz_r   <= 1'b1;
          busy_r  <= 1'b0;
        end else begin
          state_r <= DIV_NEG_IN;
          busy_r  <= 1'b1;
        end
      end else begin
        case (state_r)
          IDLE: begin
            if (dbz_r) begin
              state_r  <= DONE;
              result_r <= {WIDTH{1'b0}};
              exc_r    <= 1'b1;
              rdy_r    <= 1'b1;
            end
            busy_r <= 1'b0;
          end
          MUL: begin
            acc_r <= acc_shift_s;
            q_r   <= q_shift_s;
            q1_r  <= q_r[0];
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_r == CNT_LAST) begin
              state_r  <= DONE;
              busy_r   <= 1'b0;
              rdy_r    <= 1'b1;
              result_r <= q_shift_s;
              // product overflows when the high word is not the low word's sign extension
              exc_r    <= (acc_shift_s != {WIDTH{sum_s[0]}});
            end
          end
          DIV_NEG_IN: begin
            // 0x80000000 negates to itself, which reads correctly as unsigned 2^31
            if (opa_r[WIDTH-1]) begin
              q_r <= sum_s;
            end else begin
              q_r <= opa_r;
            end
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= DIV;
          end
          DIV: begin
            if (c32_s) begin
              acc_r <= sum_s;
            end else begin
              acc_r <= rsh_s;
            end
            q_r   <= {q_r[WIDTH-2:0], c32_s};
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_r == CNT_LAST) begin
              state_r <= DIV_NEG_OUT;
            end
          end
          DIV_NEG_OUT: begin
            q_r      <= q_fix_s;
            result_r <= q_fix_s;
            exc_r    <= (opa_r == MIN_NEG) && (opb_r == ALL_ONES);
            state_r  <= DONE;
            busy_r   <= 1'b0;
            rdy_r    <= 1'b1;
          end
          DONE: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  // outputs come straight from registers
  always_comb begin
    data_result    = result_r;
    data_exception = exc_r;
    data_resultRDY = rdy_r;
    busy           = busy_r;
  end
endmodule

// File: tb/tb_multdiv_ctrl.sv
module tb_multdiv_ctrl;
  logic        clock;
  logic        reset_n;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_checks;
  int n_fail;

  multdiv_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // drive a start pulse across one rising edge (E0); returns at E0 + 1
  task automatic start_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT     = is_mul;
    ctrl_DIV      = ~is_mul;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // count edges after E0 until RDY is seen; -1 when the budget runs out
  task automatic wait_rdy(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (data_result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h exp %h", data_result, 32'd0); end
    n_checks++; if (data_exception !== 1'b0) begin n_fail++; $display("FAIL reset_exc got %b exp 0", data_exception); end
    n_checks++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b exp 0", data_resultRDY); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_mult();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vr [4];
    logic        ve [4];
    int cyc;
    va[0] = 32'd7;        vb[0] = 32'hFFFFFFFD; vr[0] = 32'hFFFFFFEB; ve[0] = 1'b0;
    va[1] = 32'h80000000; vb[1] = 32'hFFFFFFFF; vr[1] = 32'h80000000; ve[1] = 1'b1;
    va[2] = 32'h00010000; vb[2] = 32'h00010000; vr[2] = 32'h00000000; ve[2] = 1'b1;
    va[3] = 32'hFFFFFFFB; vb[3] = 32'hFFFFFFFA; vr[3] = 32'd30;       ve[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_op(1'b1, va[i], vb[i]);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy[%0d] got %b exp 1", i, busy); end
      wait_rdy(40, cyc);
      n_checks++; if (cyc !== 32) begin n_fail++; $display("FAIL mul_latency[%0d] got %0d exp 32", i, cyc); end
      n_checks++; if (data_result !== vr[i]) begin n_fail++; $display("FAIL mul_result[%0d] got %h exp %h", i, data_result, vr[i]); end
      n_checks++; if (data_exception !== ve[i]) begin n_fail++; $display("FAIL mul_exc[%0d] got %b exp %b", i, data_exception, ve[i]); end
      @(posedge clock);
      #1;
      n_checks++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL mul_rdy_pulse[%0d] got %b exp 0", i, data_resultRDY); end
      n_checks++; if (data_result !== vr[i]) begin n_fail++; $display("FAIL mul_hold[%0d] got %h exp %h", i, data_result, vr[i]); end
    end
  endtask

  task automatic test_div();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vr [4];
    logic        ve [4];
    int cyc;
    va[0] = 32'hFFFFFF9C; vb[0] = 32'd7;        vr[0] = 32'hFFFFFFF2; ve[0] = 1'b0;
    va[1] = 32'h80000000; vb[1] = 32'hFFFFFFFF; vr[1] = 32'h80000000; ve[1] = 1'b1;
    va[2] = 32'd100;      vb[2] = 32'hFFFFFFF9; vr[2] = 32'hFFFFFFF2; ve[2] = 1'b0;
    va[3] = 32'd7;        vb[3] = 32'd100;      vr[3] = 32'd0;        ve[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_op(1'b0, va[i], vb[i]);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL div_busy[%0d] got %b exp 1", i, busy); end
      wait_rdy(40, cyc);
      n_checks++; if (cyc !== 34) begin n_fail++; $display("FAIL div_latency[%0d] got %0d exp 34", i, cyc); end
      n_checks++; if (data_result !== vr[i]) begin n_fail++; $display("FAIL div_result[%0d] got %h exp %h", i, data_result, vr[i]); end
      n_checks++; if (data_exception !== ve[i]) begin n_fail++; $display("FAIL div_exc[%0d] got %b exp %b", i, data_exception, ve[i]); end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_divzero();
    int cyc;
    start_op(1'b0, 32'd5, 32'd0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dbz_busy_e0 got %b exp 0", busy); end
    wait_rdy(5, cyc);
    n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL dbz_latency got %0d exp 1", cyc); end
    n_checks++; if (data_result !== 32'd0) begin n_fail++; $display("FAIL dbz_result got %h exp 0", data_result); end
    n_checks++; if (data_exception !== 1'b1) begin n_fail++; $display("FAIL dbz_exc got %b exp 1", data_exception); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dbz_busy_rdy got %b exp 0", busy); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int rdy_seen;
    rdy_seen = 0;
    start_op(1'b1, 32'd3, 32'd4);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_seen++;
    end
    start_op(1'b0, 32'd20, 32'd4);
    wait_rdy(40, cyc);
    if (cyc > 0) rdy_seen++;
    n_checks++; if (cyc !== 34) begin n_fail++; $display("FAIL restart_latency got %0d exp 34", cyc); end
    n_checks++; if (data_result !== 32'd5) begin n_fail++; $display("FAIL restart_result got %h exp %h", data_result, 32'd5); end
    n_checks++; if (data_exception !== 1'b0) begin n_fail++; $display("FAIL restart_exc got %b exp 0", data_exception); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_seen++;
    end
    n_checks++; if (rdy_seen !== 1) begin n_fail++; $display("FAIL restart_rdy_count got %0d exp 1", rdy_seen); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int rdy_seen;
    rdy_seen = 0;
    start_op(1'b1, 32'd6, 32'd7);
    for (int i = 1; i <= 15; i++) begin
      @(posedge clock);
      #1;
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", busy); end
    n_checks++; if (data_result !== 32'd0) begin n_fail++; $display("FAIL midrst_result got %h exp 0", data_result); end
    n_checks++; if (data_exception !== 1'b0) begin n_fail++; $display("FAIL midrst_exc got %b exp 0", data_exception); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_seen++;
    end
    n_checks++; if (rdy_seen !== 0) begin n_fail++; $display("FAIL midrst_rdy_count got %0d exp 0", rdy_seen); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got %b exp 0", busy); end
    start_op(1'b1, 32'd2, 32'd2);
    wait_rdy(40, cyc);
    n_checks++; if (cyc !== 32) begin n_fail++; $display("FAIL post_rst_latency got %0d exp 32", cyc); end
    n_checks++; if (data_result !== 32'd4) begin n_fail++; $display("FAIL post_rst_result got %h exp %h", data_result, 32'd4); end
    n_checks++; if (data_exception !== 1'b0) begin n_fail++; $display("FAIL post_rst_exc got %b exp 0", data_exception); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_mult();
    test_div();
    test_divzero();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Multicycle signed multiply/divide unit for the execute stage.
- Sequences one 32-bit carry-lookahead adder instance (ports S, ovf, A, B, Cin) through Booth radix-2 multiplication and restoring division.
- The pipeline stalls on busy and captures data_result on data_resultRDY.

Parameters:
- WIDTH, 32, operand/result width (only 32 supported).
- CNT_W, 5, iteration counter width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- ctrl_MULT  in  1  1-cycle start pulse, multiply
- ctrl_DIV  in  1  1-cycle start pulse, divide
- data_operandA  in  32  multiplicand / dividend, sampled on start
- data_operandB  in  32  multiplier / divisor, sampled on start
- data_result  out  32  product low word / quotient
- data_exception  out  1  overflow or divide-by-zero
- data_resultRDY  out  1  1-cycle result-valid strobe
- busy  out  1  high while an operation is in flight

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE; counter and working registers clear.
  - All outputs are 0.
  - Reset mid-operation abandons the operation with no resultRDY.
- States:
  - IDLE, MUL, DIV_NEG_IN, DIV, DIV_NEG_OUT, DONE.
  - busy=1 in every state except IDLE and DONE.
- Start:
  - Edge E0 samples ctrl_MULT or ctrl_DIV high in any state. Operands latch, counter clears.
  - ctrl_MULT goes to MUL. ctrl_DIV goes to DIV_NEG_IN, or to DONE if operandB==0.
  - Both high: treat as MULT.
  - Start while busy aborts the current op and restarts; the old op never signals RDY.
- Adder carry-out is derived as c32 = A31&B31 | (A31^B31)&~S31.
- Subtract is A + ~B with Cin=1. Negate is ~X + 0 with Cin=1.
- MUL (Booth):
  - Registers: acc[31:0]=0, Q=operandB, q_1=0, M=operandA.
  - Each cycle, on {Q[0],q_1}: 01 acc+M, 10 acc−M, else acc+0.
  - Then arithmetic-shift {sum,Q,q_1} right 1. The shifted-in MSB is S31 XOR ovf, giving the true sign even when M=0x80000000.
  - 32 iterations on edges E1..E32; E32 enters DONE.
  - Result = Q (low word).
  - exception = 1 if the 64-bit product {acc,Q} ≠ sign-extension of Q[31].
- DIV_NEG_IN: one cycle. dividend magnitude Dm = operandA[31] ? −operandA : operandA; 0x80000000 stays as unsigned 2^31.
- DIV (restoring):
  - Registers: R=0, Q=Dm.
  - Each cycle: R' = {R[30:0],Q[31]}.
  - Trial = R' + ~B + 1 if B positive; Trial = R' + B if B negative.
  - If c32=1: R=Trial and the shift-in quotient bit is 1. Otherwise R=R' and the bit is 0.
  - Q <= {Q[30:0],bit}.
  - 32 iterations on E2..E33.
- DIV_NEG_OUT: one cycle at E34.
  - Q = (A31^B31) ? −Q : Q, then DONE.
  - exception = 1 iff operandA=0x80000000 and operandB=0xFFFFFFFF; result is then 0x80000000.
- Divide-by-zero: enters DONE at E1 with result=0, exception=1.
- DONE:
  - data_resultRDY=1 for exactly one cycle, then IDLE.
  - data_result/data_exception are registered, written on entry to DONE, and held until the next DONE.
- Latency from start edge to RDY high:
  - MUL: 32 cycles.
  - DIV: 34 cycles.
  - Divide-by-zero: 1 cycle.
- Remainder is internal only and not exported.
- Exactly one adder instance is used; operands and Cin are muxed by state.

Test Plan:
- MULT A=7, B=−3: RDY on cycle 32 → result 0xFFFFFFEB, exception 0.
- MULT A=0x80000000, B=0xFFFFFFFF: result 0x80000000, exception 1. A=0x10000, B=0x10000: result 0, exception 1.
- DIV A=−100, B=7: RDY on cycle 34 → result 0xFFFFFFF2 (−14), exception 0. A=0x80000000, B=−1: result 0x80000000, exception 1.
- DIV A=5, B=0: RDY one cycle after start, result 0, exception 1. busy is never observed high after the start edge.
- Restart: start MULT 3×4, then DIV 20/4 at cycle 10 → exactly one RDY, at cycle 34 after the DIV pulse, result 5.
- reset_n low at cycle 15 of a MULT: outputs 0 immediately, no RDY, state IDLE. A new MULT 2×2 then returns 4 at cycle 32.
